// File: rtl/duck_hunt_pkg.sv
// Shared screen geometry, crosshair constants, FSM encoding and colours for the duck hunt slice.
package duck_hunt_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int CROSS_MARGIN = 2;
  localparam int CROSS_PIXELS = 9;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_HUNTER = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } draw_state_t;

  // Saturates a signed 9-bit coordinate into [lo, hi].
  function automatic logic [X_W-1:0] clamp_coord(input logic signed [8:0] v,
                                                 input int lo, input int hi);
    if (v < lo) return X_W'(lo);
    if (v > hi) return X_W'(hi);
    return v[X_W-1:0];
  endfunction

endpackage

// File: rtl/hunter_crosshair_if.sv
// Control/pixel bus between the draw controller (master) and hunter_crosshair (slave).
// Fire signals exist only when HUNTER_FIRE_EN is defined.
interface hunter_crosshair_if;
  import duck_hunt_pkg::*;

  logic           frame_tick;
  logic           move_left;
  logic           move_right;
  logic           move_up;
  logic           move_down;
  logic           draw_start;
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic           plot;
  logic           busy;
  logic           done;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
`ifdef HUNTER_FIRE_EN
  logic           fire;
  logic           shot_valid;
  logic [X_W-1:0] shot_x;
  logic [Y_W-1:0] shot_y;
`endif

  modport master (
    output frame_tick, move_left, move_right, move_up, move_down, draw_start,
`ifdef HUNTER_FIRE_EN
    output fire, input shot_valid, shot_x, shot_y,
`endif
    input  plot_x, plot_y, plot, busy, done, pos_x, pos_y
  );

  modport slave (
    input  frame_tick, move_left, move_right, move_up, move_down, draw_start,
`ifdef HUNTER_FIRE_EN
    input  fire, output shot_valid, shot_x, shot_y,
`endif
    output plot_x, plot_y, plot, busy, done, pos_x, pos_y
  );

endinterface

// File: rtl/crosshair_offset.sv
// Maps a sprite pixel index to its (dx, dy) offset from the crosshair centre.
module crosshair_offset (
  input  logic              [3:0] idx,
  output logic signed       [2:0] dx,
  output logic signed       [2:0] dy
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    dx = 3'sd0;
    dy = 3'sd0;
    unique case (idx)
      4'd0: dx = -3'sd2;
      4'd1: dx = -3'sd1;
      4'd3: dx =  3'sd1;
      4'd4: dx =  3'sd2;
      4'd5: dy = -3'sd2;
      4'd6: dy = -3'sd1;
      4'd7: dy =  3'sd1;
      4'd8: dy =  3'sd2;
      default: ;
    endcase
  end

endmodule

// File: rtl/hunter_crosshair.sv
// Crosshair position keeper and 9-pixel plus-sprite emitter.
// Optional shooting with cooldown is built when HUNTER_FIRE_EN is defined.
module hunter_crosshair
  import duck_hunt_pkg::*;
#(
  parameter int STEP    = 1,
  parameter int START_X = 80,
  parameter int START_Y = 60
`ifdef HUNTER_FIRE_EN
  , parameter int COOLDOWN_FRAMES = 15
`endif
) (
  input logic               clock,
  input logic               reset,
  hunter_crosshair_if.slave bus
);

  draw_state_t       state, state_n;
  logic [3:0]        idx;
  logic [X_W-1:0]    snap_x;
  logic [Y_W-1:0]    snap_y;
  logic              pending_move;
  logic              last_pixel;
  logic              do_move;
  logic signed [2:0] dx, dy;
  logic signed [8:0] step_x, step_y, next_x, next_y;

  crosshair_offset u_offset (.idx(idx), .dx(dx), .dy(dy));

  assign last_pixel = (state == ST_EMIT) && (idx == 4'(CROSS_PIXELS - 1));
  // Ticks seen while emitting are folded into a single step on the edge into DONE.
  assign do_move = (state != ST_EMIT) ? bus.frame_tick
                                      : (last_pixel && (pending_move || bus.frame_tick));

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    bus.plot = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      ST_IDLE: if (bus.draw_start) state_n = ST_EMIT;
      ST_EMIT: begin
        bus.plot = 1'b1;
        bus.busy = 1'b1;
        if (last_pixel) state_n = ST_DONE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_n  = bus.draw_start ? ST_EMIT : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.plot_x = (state == ST_EMIT) ? snap_x + {{(X_W-3){dx[2]}}, dx} : '0;
  assign bus.plot_y = (state == ST_EMIT) ? snap_y + {{(Y_W-3){dy[2]}}, dy} : '0;

  // Opposing directions on an axis cancel; up is towards y = 0.
  always_comb begin
    step_x = '0;
    step_y = '0;
    if (bus.move_right && !bus.move_left) step_x =  9'(STEP);
    if (bus.move_left && !bus.move_right) step_x = -9'(STEP);
    if (bus.move_down && !bus.move_up)    step_y =  9'(STEP);
    if (bus.move_up && !bus.move_down)    step_y = -9'(STEP);
  end

  assign next_x = $signed({1'b0, bus.pos_x}) + step_x;
  assign next_y = $signed({2'b00, bus.pos_y}) + step_y;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      snap_x       <= '0;
      snap_y       <= '0;
      pending_move <= 1'b0;
      bus.pos_x    <= X_W'(START_X);
      bus.pos_y    <= Y_W'(START_Y);
    end else begin
      if (state != ST_EMIT && bus.draw_start) begin
        idx    <= '0;
        snap_x <= bus.pos_x;
        snap_y <= bus.pos_y;
      end else if (state == ST_EMIT && !last_pixel) begin
        idx <= idx + 4'd1;
      end

      if (do_move)                               pending_move <= 1'b0;
      else if (state == ST_EMIT && bus.frame_tick) pending_move <= 1'b1;

      if (do_move) begin
        bus.pos_x <= clamp_coord(next_x, CROSS_MARGIN, SCREEN_W - 1 - CROSS_MARGIN);
        bus.pos_y <= Y_W'(clamp_coord(next_y, CROSS_MARGIN, SCREEN_H - 1 - CROSS_MARGIN));
      end
    end
  end

`ifdef HUNTER_FIRE_EN
  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

  logic            prev_fire;
  logic [CD_W-1:0] cooldown;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_fire      <= 1'b0;
      cooldown       <= '0;
      bus.shot_valid <= 1'b0;
      bus.shot_x     <= '0;
      bus.shot_y     <= '0;
    end else begin
      prev_fire      <= bus.fire;
      bus.shot_valid <= 1'b0;
      if (bus.fire && !prev_fire && cooldown == '0) begin
        bus.shot_valid <= 1'b1;
        bus.shot_x     <= bus.pos_x;
        bus.shot_y     <= bus.pos_y;
        cooldown       <= CD_W'(COOLDOWN_FRAMES);
      end else if (bus.frame_tick && cooldown != '0) begin
        cooldown <= cooldown - 1'b1;
      end
    end
  end
`endif

endmodule
